// File: rtl/cursor_pkg.sv
// Shared constants and types for the 4x4 cursor-cell overlay on a 640x480 frame.
package cursor_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned CELL_W       = 160;
  localparam int unsigned CELL_H       = 120;
  localparam int unsigned GRID_N       = 4;
  localparam int unsigned BORDER_W     = 4;
  localparam int unsigned BLINK_FRAMES = 30;
  localparam int unsigned BLINK_CNT_W  = $clog2(BLINK_FRAMES);

  typedef logic [3:0] cell_idx_t;

endpackage

// File: rtl/blink_timer.sv
// Frame-rate blink generator: toggles visibility every BLINK_FRAMES ticks, restart forces visible.
module blink_timer
  import cursor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic restart_i,
  output logic blink_vis_o
);

  localparam logic [BLINK_CNT_W-1:0] CntMax = BLINK_CNT_W'(BLINK_FRAMES - 1);

  logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;
  logic                   vis_q, vis_d;

  always_comb begin
    cnt_d = cnt_q;
    vis_d = vis_q;
    if (tick_i) begin
      // A restart outranks a wrap landing on the same tick.
      if (restart_i) begin
        cnt_d = '0;
        vis_d = 1'b1;
      end else if (cnt_q == CntMax) begin
        cnt_d = '0;
        vis_d = ~vis_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      vis_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      vis_q <= vis_d;
    end
  end

  assign blink_vis_o = vis_q;

endmodule

// File: rtl/cursor_overlay.sv
// Hollow-border highlight of one 160x120 cell in a 4x4 grid; cell latched per frame.
// Define CURSOR_BLINK_EN to add the frame-counted blink (blink_timer); otherwise always visible.
module cursor_overlay
  import cursor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  cell_idx_t  pos_cursor,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_start,
  output logic       cursor_on,
  output cell_idx_t  cursor_cell
);

  localparam logic [9:0] XSplit1 = 10'(CELL_W);
  localparam logic [9:0] XSplit2 = 10'(2 * CELL_W);
  localparam logic [9:0] XSplit3 = 10'(3 * CELL_W);
  localparam logic [9:0] YSplit1 = 10'(CELL_H);
  localparam logic [9:0] YSplit2 = 10'(2 * CELL_H);
  localparam logic [9:0] YSplit3 = 10'(3 * CELL_H);
  localparam logic [9:0] HLimit  = 10'(H_VISIBLE);
  localparam logic [9:0] VLimit  = 10'(V_VISIBLE);
  localparam logic [9:0] BordLo  = 10'(BORDER_W);
  localparam logic [9:0] XBordHi = 10'(CELL_W - BORDER_W);
  localparam logic [9:0] YBordHi = 10'(CELL_H - BORDER_W);

  cell_idx_t  cursor_cell_q, cursor_cell_d;
  logic       cursor_on_q, cursor_on_d;
  logic [1:0] col, row;
  logic [9:0] x_off, y_off;
  logic       in_vis, border, hit, blink_vis;

  // Divide-free cell decode: the grid is only 4 wide, so compare against the split points.
  always_comb begin
    col   = 2'd3;
    x_off = pixel_x - XSplit3;
    if (pixel_x < XSplit1) begin
      col   = 2'd0;
      x_off = pixel_x;
    end else if (pixel_x < XSplit2) begin
      col   = 2'd1;
      x_off = pixel_x - XSplit1;
    end else if (pixel_x < XSplit3) begin
      col   = 2'd2;
      x_off = pixel_x - XSplit2;
    end
  end

  always_comb begin
    row   = 2'd3;
    y_off = pixel_y - YSplit3;
    if (pixel_y < YSplit1) begin
      row   = 2'd0;
      y_off = pixel_y;
    end else if (pixel_y < YSplit2) begin
      row   = 2'd1;
      y_off = pixel_y - YSplit1;
    end else if (pixel_y < YSplit3) begin
      row   = 2'd2;
      y_off = pixel_y - YSplit2;
    end
  end

  always_comb begin
    in_vis = video_on && (pixel_x < HLimit) && (pixel_y < VLimit);
    border = (x_off < BordLo) || (x_off >= XBordHi) || (y_off < BordLo) || (y_off >= YBordHi);
    hit    = in_vis && border && ({row, col} == cursor_cell_q);
  end

`ifdef CURSOR_BLINK_EN
  logic cell_change;

  assign cell_change = frame_start && (pos_cursor != cursor_cell_q);

  blink_timer u_blink_timer (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (frame_start),
    .restart_i   (cell_change),
    .blink_vis_o (blink_vis)
  );
`else
  assign blink_vis = 1'b1;
`endif

  always_comb begin
    cursor_cell_d = cursor_cell_q;
    if (frame_start) begin
      cursor_cell_d = pos_cursor;
    end
    cursor_on_d = hit && blink_vis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_cell_q <= '0;
      cursor_on_q   <= 1'b0;
    end else begin
      cursor_cell_q <= cursor_cell_d;
      cursor_on_q   <= cursor_on_d;
    end
  end

  assign cursor_on   = cursor_on_q;
  assign cursor_cell = cursor_cell_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Scoreboard bench for cursor_overlay; blink checks are compiled in when CURSOR_BLINK_EN is defined.
module tb_cursor_overlay;
  import cursor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  cell_idx_t  pos_cursor = '0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       video_on = 1'b0;
  logic       frame_start = 1'b0;
  logic       cursor_on;
  cell_idx_t  cursor_cell;

  cursor_overlay dut (
    .clk         (clk),
    .rst         (rst),
    .pos_cursor  (pos_cursor),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .cursor_on   (cursor_on),
    .cursor_cell (cursor_cell)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } exp_t;

  exp_t on_q[$];
  exp_t cell_q[$];
  logic trk = 1'b0, trk_d = 1'b0, creq = 1'b0, creq_d = 1'b0;
  logic stop_req = 1'b0, stopped = 1'b0;
  int   n_pass = 0, n_total = 0;

  // Request flags travel through one register, matching the DUT's output latency.
  always @(posedge clk) begin
    trk_d  <= trk;
    creq_d <= creq;
  end

  always @(negedge clk) begin
    exp_t e;
    if (trk_d) begin
      n_total++;
      if (on_q.size() == 0) begin
        $display("FAIL on_underflow: queue empty, want an entry");
      end else begin
        e = on_q.pop_front();
        if (cursor_on === e.exp[0]) n_pass++;
        else $display("FAIL %s: cursor_on=%0b want %0b", e.name, cursor_on, e.exp[0]);
      end
    end
    if (creq_d) begin
      n_total++;
      if (cell_q.size() == 0) begin
        $display("FAIL cell_underflow: queue empty, want an entry");
      end else begin
        e = cell_q.pop_front();
        if (cursor_cell === e.exp) n_pass++;
        else $display("FAIL %s: cursor_cell=%0d want %0d", e.name, cursor_cell, e.exp);
      end
    end
    if (stop_req && !stopped) begin
      n_total++;
      if (on_q.size() == 0 && cell_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left want 0", on_q.size() + cell_q.size());
      stopped <= 1'b1;
    end
  end

  // All tasks start and end at a falling edge.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v, input logic e,
                     input string n);
    exp_t t;
    t.name   = n;
    t.exp    = {3'b000, e};
    pixel_x  = x;
    pixel_y  = y;
    video_on = v;
    trk      = 1'b1;
    on_q.push_back(t);
    @(negedge clk);
    trk      = 1'b0;
    video_on = 1'b0;
  endtask

  task automatic chk_cell(input logic [3:0] e, input string n);
    exp_t t;
    t.name = n;
    t.exp  = e;
    creq   = 1'b1;
    cell_q.push_back(t);
    @(negedge clk);
    creq = 1'b0;
  endtask

  task automatic frame(input logic [3:0] p);
    pos_cursor  = p;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    pix(10'd0, 10'd0, 1'b1, 1'b0, "rst_on_a");
    pix(10'd0, 10'd0, 1'b1, 1'b0, "rst_on_b");
    chk_cell(4'd0, "rst_cell");
    rst = 1'b0;

    frame(4'd5);
    chk_cell(4'd5, "cell_after_reset");

    pix(10'd160, 10'd120, 1'b1, 1'b1, "geo_160_120");
    pix(10'd163, 10'd200, 1'b1, 1'b1, "geo_163_200");
    pix(10'd319, 10'd239, 1'b1, 1'b1, "geo_319_239");
    pix(10'd164, 10'd124, 1'b1, 1'b0, "geo_164_124");
    pix(10'd159, 10'd120, 1'b1, 1'b0, "geo_159_120");
    pix(10'd320, 10'd120, 1'b1, 1'b0, "geo_320_120");

    pos_cursor = 4'd9;
    pix(10'd160, 10'd120, 1'b1, 1'b1, "tear_old_on");
    chk_cell(4'd5, "tear_hold");
    frame(4'd9);
    chk_cell(4'd9, "tear_new");
    pix(10'd160, 10'd120, 1'b1, 1'b0, "tear_old_off");
    pix(10'd160, 10'd240, 1'b1, 1'b1, "cell9_on");

    frame(4'd5);
    pix(10'd160, 10'd120, 1'b0, 1'b0, "blank_von0");
    frame(4'd3);
    pix(10'd639, 10'd0, 1'b1, 1'b1, "c3_edge");
    pix(10'd640, 10'd0, 1'b1, 1'b0, "c3_xover");
    frame(4'd15);
    pix(10'd480, 10'd479, 1'b1, 1'b1, "c15_ybot");
    pix(10'd480, 10'd480, 1'b1, 1'b0, "c15_yover");

`ifdef CURSOR_BLINK_EN
    // Counter was cleared by the move to cell 15.
    for (int i = 0; i < 29; i++) frame(4'd15);
    pix(10'd480, 10'd360, 1'b1, 1'b1, "blink_pre_wrap");
    frame(4'd15);
    pix(10'd480, 10'd360, 1'b1, 1'b0, "blink_off");
    for (int i = 0; i < 29; i++) frame(4'd15);
    pix(10'd480, 10'd360, 1'b1, 1'b0, "blink_still_off");
    frame(4'd15);
    pix(10'd480, 10'd360, 1'b1, 1'b1, "blink_on_again");

    for (int i = 0; i < 30; i++) frame(4'd15);
    pix(10'd480, 10'd360, 1'b1, 1'b0, "hidden_before_move");
    frame(4'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b1, "restart_vis");
    for (int i = 0; i < 29; i++) frame(4'd0);
    frame(4'd1);
    pix(10'd160, 10'd0, 1'b1, 1'b1, "wrap_with_move");
    for (int i = 0; i < 29; i++) frame(4'd1);
    pix(10'd160, 10'd0, 1'b1, 1'b1, "cnt_cleared_vis");
    frame(4'd1);
    pix(10'd160, 10'd0, 1'b1, 1'b0, "cnt_cleared_off");
`else
    for (int i = 0; i < 60; i++) begin
      frame(4'd15);
      pix(10'd480, 10'd360, 1'b1, 1'b1, $sformatf("noblink_%0d", i));
    end
`endif

    repeat (3) @(negedge clk);
    stop_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cursor_overlay.md
CURSOR_OVERLAY -- requirements
Module: cursor_overlay

Interface
REQ-001 clk  input  1  system/pixel clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 pos_cursor  input  4  cursor cell index 0..15 from the cursor counter; asynchronous to frame timing.
REQ-004 pixel_x  input  10  current pixel column from the VGA timing generator, 0..639 when visible.
REQ-005 pixel_y  input  10  current pixel row, 0..479 when visible.
REQ-006 video_on  input  1  high while (pixel_x, pixel_y) is in the visible area.
REQ-007 frame_start  input  1  one-cycle pulse at the first cycle of each frame (start of vertical blanking).
REQ-008 cursor_on  output  1  high when the current pixel belongs to the cursor highlight.
REQ-009 cursor_cell  output  4  cursor cell index latched for the current frame.

Function
REQ-010 The screen is divided into a 4x4 grid of cells, each 160 px wide by 120 px high; column = pixel_x/160, row = pixel_y/120, cell = row*4 + column.
REQ-011 pos_cursor is sampled into cursor_cell only on cycles where frame_start=1; cursor_cell is constant for the rest of the frame (no tearing).
REQ-012 The highlight is a hollow border BORDER_W=4 px thick on the inside edge of the selected cell: the pixel is in the cell and (x_in_cell<4 or x_in_cell>=156 or y_in_cell<4 or y_in_cell>=116).
REQ-013 cursor_on is registered: it reflects the inputs pixel_x/pixel_y/video_on sampled on the previous cycle (latency exactly 1 cycle).
REQ-014 cursor_on is 0 whenever video_on was 0, or pixel_x>=640, or pixel_y>=480, on the sampled cycle.
REQ-015 A frame counter counts frame_start pulses modulo BLINK_FRAMES=30; at each wrap the visibility flag blink_vis toggles.
REQ-016 cursor_on = border hit AND blink_vis.
REQ-017 When the value sampled at frame_start differs from the previous cursor_cell, the frame counter clears to 0 and blink_vis is set to 1 in that same cycle (the new position is shown immediately).
REQ-018 A wrap and a position change in the same frame_start cycle: the position change takes priority (counter 0, blink_vis 1).
REQ-019 Wrap from cell 15 to cell 0 is an ordinary position change; no special casing.

Reset
REQ-020 While rst=1: cursor_cell=0, cursor_on=0, frame counter=0, blink_vis=1; rst dominates frame_start.
REQ-021 Reset asserted mid-frame takes effect on the next edge; the first frame_start after deassertion samples pos_cursor normally.

Configuration
REQ-022 With macro CURSOR_BLINK_EN defined, the blink logic of REQ-015..REQ-018 is present.
REQ-023 Without CURSOR_BLINK_EN, blink_vis is constant 1, no frame counter is instantiated, and cursor_on = border hit.

Structure
REQ-024 Package cursor_pkg holds H_VISIBLE=640, V_VISIBLE=480, CELL_W=160, CELL_H=120, GRID_N=4, BORDER_W=4, BLINK_FRAMES=30 and typedef cell_idx_t (logic [3:0]).
REQ-025 Sub-module blink_timer (frame counter + blink_vis, with a restart input) is instantiated only under CURSOR_BLINK_EN.

Verification
REQ-026 Reset: hold rst 3 cycles -> cursor_on=0, cursor_cell=0; release, pulse frame_start with pos_cursor=5 -> cursor_cell=5.
REQ-027 Geometry: cursor_cell=5 (row 1, col 1), video_on=1 -> cursor_on=1 one cycle after (160,120), (163,200), (319,239); 0 after (164,124), (159,120), (320,120).
REQ-028 Tearing: change pos_cursor 5->9 mid-frame -> cursor_cell stays 5 until next frame_start, then 9.
REQ-029 Blink (CURSOR_BLINK_EN): constant pos, 30 frame_start pulses -> blink_vis goes 0, border pixels give cursor_on=0; 30 more -> visible again.
REQ-030 Restart: while invisible, frame_start with new pos 15->0 -> blink_vis=1 immediately, counter 0; same frame as a wrap -> still visible.
REQ-031 Blanking: video_on=0 with (x,y) on the border -> cursor_on=0; without CURSOR_BLINK_EN, 60 frames -> cursor_on never drops on border pixels.
